mac_result_div: RTL and testbench
=================================

# mac_result_div

Iterative restoring divider that inverts the pipelined multiply-add result path. It takes the 17-bit `result` word and the 8-bit multiplier operand `b`, and recovers `a` as the quotient and `c` as the remainder, provided `c < b`. It sits on the consumer side of the multiply-add pipeline as a self-check and unpack stage. It uses valid/ready handshakes on both sides and holds at most one operation in flight.

## Interface

- `DW_N`, 17: dividend and quotient width.
- `DW_D`, 8: divisor and remainder width.

Ports:

- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: dividend and divisor are presented.
- `in_ready` output 1: block can accept an operation; high only in IDLE.
- `dividend` input `DW_N`: numerator, unsigned.
- `divisor` input `DW_D`: denominator, unsigned.
- `out_valid` output 1: quotient, remainder and flag are valid.
- `out_ready` input 1: downstream accepts the result.
- `quotient` output `DW_N`: `dividend / divisor`, unsigned.
- `remainder` output `DW_D`: `dividend % divisor`.
- `div_by_zero` output 1: set with `out_valid` when the captured divisor was 0.

## Operation

- **State machine**
  - IDLE: on `in_valid && in_ready`, capture `dividend` and `divisor`.
    - If the divisor is 0, go to DONE.
    - Otherwise go to CALC with the bit counter set to 0.
  - CALC: perform one restoring step per cycle for `DW_N` cycles, then go to DONE.
  - DONE: `out_valid = 1`. On `out_valid && out_ready`, go to IDLE.
- **Step, MSB first**
  - Form the partial remainder `pr = {rem, next dividend bit}`, `DW_D+1` bits wide.
  - If `pr >= divisor`: `rem = pr - divisor` and the quotient bit is 1.
  - Else: `rem = pr[DW_D-1:0]` and the quotient bit is 0.
  - `rem` is always `< divisor`, so `DW_D` bits suffice.
- **Divide by zero**
  - `quotient = {DW_N{1'b1}}`.
  - `remainder = dividend[DW_D-1:0]`.
  - `div_by_zero = 1`.
  - No CALC cycles are spent.
- **Input capture**
  - Inputs are sampled only at the accepting edge.
  - Later changes to `dividend` or `divisor` have no effect.
  - `in_valid` is ignored outside IDLE.
- **Output hold**
  - `quotient`, `remainder` and `div_by_zero` are registered.
  - They hold stable from `out_valid` rising until the handshake completes.
  - `quotient` and `remainder` keep their value afterwards until the next result loads.
  - `div_by_zero` clears when a non-zero-divisor result loads.
- **Reset**
  - `rst` high at any edge, including mid-CALC or in DONE, drops the operation.
  - Next state is IDLE; `out_valid`, `quotient`, `remainder` and `div_by_zero` go to 0.
  - No partial result is ever emitted.

## Timing

- Reset values:
  - `in_ready = 1` (IDLE).
  - `out_valid = 0`, `quotient = 0`, `remainder = 0`, `div_by_zero = 0`.
- Latency, with the accepting edge as T0:
  - Normal division: CALC steps occur at edges T1..T17, and `out_valid` is high after T17 (17 cycles).
  - Divide by zero: `out_valid` is high after T0 (1 cycle).
- `in_ready` is combinational from state: 1 in IDLE, 0 in CALC and DONE.
- Throughput:
  - The output handshake at edge Tk returns the block to IDLE.
  - The earliest next accept is at Tk+1.
  - There is no same-edge accept-and-release.
- Back-pressure: with `out_ready` low, DONE persists indefinitely; outputs stay stable and `in_ready` stays 0.
- Reset has priority over every handshake at the same edge.

## Test plan

1. **Exact recovery.** Send `dividend = 5007` (100·50+7) with `divisor = 50`.
   - Expect `quotient = 100`, `remainder = 7`, `div_by_zero = 0`.
   - `out_valid` rises exactly 17 cycles after accept.
2. **Divide by zero.** Send `dividend = 0x01234` with `divisor = 0`.
   - After 1 cycle expect `out_valid = 1`, `quotient = 0x1FFFF`, `remainder = 0x34`, `div_by_zero = 1`.
   - The next operation, 300/7, returns `quotient = 42`, `remainder = 6`, `div_by_zero = 0`.
3. **Width extremes.**
   - `0x1FFFF / 1`: `quotient = 131071`, `remainder = 0`.
   - `0x1FFFF / 255`: `quotient = 514`, `remainder = 1`.
   - `0 / 9`: `quotient = 0`, `remainder = 0`.
4. **Back-pressure.** Hold `out_ready = 0` for 5 cycles after `out_valid` rises, and toggle `in_valid` with new data meanwhile.
   - Outputs stay unchanged and `in_ready` stays 0.
   - The new data is not consumed.
   - After `out_ready` is pulsed, `in_ready` returns to 1 one cycle later.
5. **Reset mid-CALC.** Assert `rst` for one edge 8 cycles into an operation.
   - `out_valid` never rises for that operation.
   - All outputs are 0 and `in_ready = 1` after the reset edge.
   - A following 5007/50 still gives 100 r 7.
6. **Randomized round trip.** Run 200 operations with `a, b` in 1..100 and `c` in 0..b-1, and `dividend = a·b + c`, `divisor = b`.
   - Every result gives `quotient = a`, `remainder = c`.
   - Use random `out_ready` stalls.

Source files
------------

// File: rtl/mac_result_div_if.sv
// Handshake and payload bundle for the mac_result_div unpack/self-check divider.
interface mac_result_div_if #(
  parameter int unsigned DW_N = 17,
  parameter int unsigned DW_D = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [DW_N-1:0] dividend;
  logic [DW_D-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [DW_N-1:0] quotient;
  logic [DW_D-1:0] remainder;
  logic            div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/mac_result_div.sv
// Iterative restoring divider: recovers a (quotient) and c (remainder) from result = a*b + c.
// One restoring step per cycle, MSB first, one operation in flight.
module mac_result_div #(
  parameter int unsigned DW_N = 17,
  parameter int unsigned DW_D = 8
) (
  input  logic             clk,
  input  logic             rst,
  mac_result_div_if.slave  bus
);
  localparam int unsigned CW = $clog2(DW_N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [DW_N-1:0] shf_q;
  logic [DW_D-1:0] dsr_q;
  logic [DW_D-1:0] rem_q;
  logic [CW-1:0]   cnt_q;
  logic [DW_N-1:0] quo_out_q;
  logic [DW_D-1:0] rem_out_q;
  logic            dbz_q;

  logic            accept;
  logic            last_step;
  logic [DW_D:0]   pr;
  logic [DW_D:0]   diff;
  logic            ge;
  logic [DW_D-1:0] rem_nxt;
  logic [DW_N-1:0] shf_nxt;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_step = (cnt_q == CW'(DW_N - 1));

  // Single restoring step: shift dividend bits into the partial remainder, quotient bits in at the LSB.
  always_comb begin
    pr      = {rem_q, shf_q[DW_N-1]};
    diff    = pr - {1'b0, dsr_q};
    ge      = (pr >= {1'b0, dsr_q});
    rem_nxt = ge ? diff[DW_D-1:0] : pr[DW_D-1:0];
    shf_nxt = {shf_q[DW_N-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = (bus.divisor == '0) ? DONE : CALC;
      CALC: if (last_step)    state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Working registers plus result registers that hold until the next result loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      shf_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else if (accept) begin
      shf_q <= bus.dividend;
      dsr_q <= bus.divisor;
      rem_q <= '0;
      cnt_q <= '0;
      if (bus.divisor == '0) begin
        quo_out_q <= '1;
        rem_out_q <= bus.dividend[DW_D-1:0];
        dbz_q     <= 1'b1;
      end
    end else if (state == CALC) begin
      shf_q <= shf_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q + CW'(1);
      if (last_step) begin
        quo_out_q <= shf_nxt;
        rem_out_q <= rem_nxt;
        dbz_q     <= 1'b0;
      end
    end
  end

  assign bus.quotient    = quo_out_q;
  assign bus.remainder   = rem_out_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mac_result_div.sv
// Directed and randomized checks of mac_result_div against an arithmetic reference model.
module tb_mac_result_div;
  localparam int unsigned DW_N = 17;
  localparam int unsigned DW_D = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  mac_result_div_if #(.DW_N(DW_N), .DW_D(DW_D)) bus ();

  mac_result_div #(.DW_N(DW_N), .DW_D(DW_D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, check latency and result, optionally stall and scribble inputs, then release.
  task automatic run_op(input logic [DW_N-1:0] a, input logic [DW_D-1:0] b,
                        input int stall, input bit toggle);
    logic [DW_N-1:0] eq;
    logic [DW_D-1:0] er;
    logic            ez;
    int              cyc;
    if (b == '0) begin
      eq = '1;
      er = a[DW_D-1:0];
      ez = 1'b1;
    end else begin
      eq = a / DW_N'(b);
      er = DW_D'(a % DW_N'(b));
      ez = 1'b0;
    end
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.dividend = DW_N'($urandom);
    bus.divisor  = DW_D'($urandom);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("latency", 32'(cyc), (b == '0) ? 32'd0 : 32'd17);
    chk("quotient", 32'(bus.quotient), 32'(eq));
    chk("remainder", 32'(bus.remainder), 32'(er));
    chk("div_by_zero", 32'(bus.div_by_zero), 32'(ez));
    for (int i = 0; i < stall; i++) begin
      if (toggle) begin
        bus.in_valid = i[0];
        bus.dividend = DW_N'($urandom);
        bus.divisor  = DW_D'($urandom);
      end
      tick();
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_quotient", 32'(bus.quotient), 32'(eq));
      chk("hold_remainder", 32'(bus.remainder), 32'(er));
      chk("hold_dbz", 32'(bus.div_by_zero), 32'(ez));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("release_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("kept_quotient", 32'(bus.quotient), 32'(eq));
    chk("kept_remainder", 32'(bus.remainder), 32'(er));
  endtask

  initial begin
    logic [DW_N-1:0] a, dvd;
    logic [DW_D-1:0] b, c;
    bit              seen_valid;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);

    // Exact recovery, divide by zero and the follow-up clearing the flag.
    run_op(17'd5007, 8'd50, 0, 1'b0);
    run_op(17'h01234, 8'd0, 0, 1'b0);
    chk("dz_quotient_const", 32'(bus.quotient), 32'h1FFFF);
    run_op(17'd300, 8'd7, 0, 1'b0);
    chk("after_dz_quotient", 32'(bus.quotient), 32'd42);

    // Width extremes.
    run_op(17'h1FFFF, 8'd1, 0, 1'b0);
    run_op(17'h1FFFF, 8'd255, 0, 1'b0);
    chk("max_by_255_q", 32'(bus.quotient), 32'd514);
    run_op(17'd0, 8'd9, 0, 1'b0);

    // Back-pressure with input churn during the stall.
    run_op(17'd12345, 8'd99, 5, 1'b1);

    // Reset in the middle of a calculation.
    bus.dividend = 17'd5007;
    bus.divisor  = 8'd50;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) seen_valid = 1'b1;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_quotient", 32'(bus.quotient), 32'd0);
    chk("midrst_remainder", 32'(bus.remainder), 32'd0);
    chk("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) seen_valid = 1'b1;
    end
    chk("midrst_no_output", 32'(seen_valid), 32'd0);
    run_op(17'd5007, 8'd50, 0, 1'b0);

    // Randomized round trip: dividend = a*b + c with c < b.
    for (int n = 0; n < 200; n++) begin
      a   = DW_N'($urandom_range(1, 100));
      b   = DW_D'($urandom_range(1, 100));
      c   = DW_D'($urandom_range(0, int'(b) - 1));
      dvd = DW_N'(a * DW_N'(b) + DW_N'(c));
      run_op(dvd, b, int'($urandom_range(0, 3)), 1'b0);
      chk("rt_a", 32'(bus.quotient), 32'(a));
      chk("rt_c", 32'(bus.remainder), 32'(c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
